// File: rtl/fsm_step_ctrl.sv
// fsm_step_ctrl: step scheduler for the lab Mealy FSMs.
//
// Decides when the student FSM advances (step_en) and which input bit it
// sees on that step (fsm_in). Step sources:
//   mode 0 pause, 1 auto-rate divider, 2 debounced single-step button,
//   3 playback of a loaded bit pattern (LSB first).
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   mode[1:0]       step source select, sampled every cycle
//   btn             raw pushbutton (asynchronous, bouncy)
//   in_manual       FSM input bit for auto and single modes
//   pat_load        one-cycle strobe capturing pat_data / pat_len
//   pat_data        pattern bits, played LSB first
//   pat_len[3:0]    pattern length, clamped to PAT_W
//   step_en         one-cycle advance pulse for the FSM state register
//   fsm_in          FSM input bit, valid while step_en=1, held otherwise
//   step_cnt[7:0]   steps issued since reset or last pat_load (wraps)
//   pat_done        pattern fully played; held until mode change/load
module fsm_step_ctrl #(
    parameter int CNT_MAX   = 49_999_999,
    parameter int DB_CYCLES = 1_000_000,
    parameter int PAT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             btn,
    input  logic             in_manual,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_data,
    input  logic [3:0]       pat_len,
    output logic             step_en,
    output logic             fsm_in,
    output logic [7:0]       step_cnt,
    output logic             pat_done
);

    localparam int DIV_W = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int DB_W  = $clog2(DB_CYCLES + 1);
    localparam int LEN_W = $clog2(PAT_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AUTO,
        S_SINGLE,
        S_PATTERN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic               step_en_q, step_en_d;
    logic               fsm_in_q, fsm_in_d;
    logic [7:0]         step_cnt_q, step_cnt_d;
    logic               pat_done_q, pat_done_d;
    logic [1:0]         sync_q, sync_d;
    logic               db_lvl_q, db_lvl_d;
    logic               db_prev_q, db_prev_d;
    logic [DB_W-1:0]    db_cnt_q, db_cnt_d;

    state_t             mode_state;
    logic               in_mode;
    logic               tick;
    logic               press;
    logic               pat_bit;
    logic [DIV_W-1:0]   div_nxt;
    logic [LEN_W-1:0]   idx_inc;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        idx_d      = idx_q;
        len_d      = len_q;
        pat_d      = pat_q;
        step_en_d  = 1'b0;
        fsm_in_d   = fsm_in_q;
        step_cnt_d = step_cnt_q + 8'(step_en_q);
        pat_done_d = pat_done_q;
        sync_d     = {sync_q[0], btn};
        db_lvl_d   = db_lvl_q;
        db_prev_d  = db_lvl_q;
        db_cnt_d   = db_cnt_q;

        // Debounce: the level must differ for DB_CYCLES consecutive cycles.
        if (sync_q[1] != db_lvl_q) begin
            if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
                db_lvl_d = sync_q[1];
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end else begin
            db_cnt_d = '0;
        end
        press = db_lvl_q & ~db_prev_q;

        case (mode)
            2'd0:    mode_state = S_IDLE;
            2'd1:    mode_state = S_AUTO;
            2'd2:    mode_state = S_SINGLE;
            default: mode_state = S_PATTERN;
        endcase
        // DONE is the finished half of mode 3, so it is not a mismatch.
        in_mode = (state_q == mode_state) || (state_q == S_DONE && mode == 2'd3);

        tick    = (div_q == DIV_W'(CNT_MAX));
        div_nxt = tick ? '0 : div_q + DIV_W'(1);
        idx_inc = idx_q + LEN_W'(1);
        pat_bit = |(pat_q & (PAT_W'(1) << idx_q));

        if (!in_mode) begin
            state_d    = mode_state;
            div_d      = '0;
            idx_d      = '0;
            pat_done_d = 1'b0;
        end else begin
            case (state_q)
                S_AUTO: begin
                    div_d = div_nxt;
                    if (tick) begin
                        step_en_d = 1'b1;
                        fsm_in_d  = in_manual;
                    end
                end
                S_SINGLE: begin
                    if (press) begin
                        step_en_d = 1'b1;
                        fsm_in_d  = in_manual;
                    end
                end
                S_PATTERN: begin
                    if (len_q == '0) begin
                        state_d    = S_DONE;
                        pat_done_d = 1'b1;
                        div_d      = '0;
                    end else begin
                        div_d = div_nxt;
                        if (tick) begin
                            step_en_d = 1'b1;
                            fsm_in_d  = pat_bit;
                            idx_d     = idx_inc;
                            if (idx_inc == len_q) begin
                                state_d    = S_DONE;
                                pat_done_d = 1'b1;
                            end
                        end
                    end
                end
                default: div_d = '0;
            endcase
        end

        // A load overrides any step decided above, including a coinciding tick.
        if (pat_load) begin
            pat_d      = pat_data;
            len_d      = (32'(pat_len) > PAT_W) ? LEN_W'(PAT_W) : LEN_W'(pat_len);
            idx_d      = '0;
            div_d      = '0;
            step_cnt_d = '0;
            pat_done_d = 1'b0;
            step_en_d  = 1'b0;
            fsm_in_d   = fsm_in_q;
            if (state_d == S_DONE) state_d = S_PATTERN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            idx_q      <= '0;
            len_q      <= '0;
            pat_q      <= '0;
            step_en_q  <= 1'b0;
            fsm_in_q   <= 1'b0;
            step_cnt_q <= '0;
            pat_done_q <= 1'b0;
            sync_q     <= '0;
            db_lvl_q   <= 1'b0;
            db_prev_q  <= 1'b0;
            db_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            pat_q      <= pat_d;
            step_en_q  <= step_en_d;
            fsm_in_q   <= fsm_in_d;
            step_cnt_q <= step_cnt_d;
            pat_done_q <= pat_done_d;
            sync_q     <= sync_d;
            db_lvl_q   <= db_lvl_d;
            db_prev_q  <= db_prev_d;
            db_cnt_q   <= db_cnt_d;
        end
    end

    assign step_en  = step_en_q;
    assign fsm_in   = fsm_in_q;
    assign step_cnt = step_cnt_q;
    assign pat_done = pat_done_q;

endmodule

// File: doc/fsm_step_ctrl.md
Name: fsm_step_ctrl

Overview:
Step scheduler for the lab Mealy FSMs. It decides when the FSM advances and which input bit it sees on that step. Step sources are an auto-rate divider, a debounced single-step button, or playback of a loaded bit pattern. Outputs are a one-cycle step_en that gates the FSM state register, a matching fsm_in bit, and a step counter for the hex displays.

Parameters:
CNT_MAX, 49_999_999, divider terminal count; one auto/pattern step every CNT_MAX+1 cycles
DB_CYCLES, 1_000_000, consecutive stable cycles needed to accept a new button level
PAT_W, 8, pattern register width in bits

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
mode  input  2  0=pause, 1=auto, 2=single-step, 3=pattern playback
btn  input  1  raw step pushbutton (asynchronous, bouncy)
in_manual  input  1  FSM input bit used in auto and single modes
pat_load  input  1  one-cycle strobe; capture pat_data and pat_len
pat_data  input  PAT_W  pattern bits, played LSB first
pat_len  input  4  number of pattern steps; values above PAT_W clamp to PAT_W
step_en  output  1  one-cycle pulse; FSM advances on this cycle
fsm_in  output  1  FSM input bit, valid while step_en=1
step_cnt  output  8  steps issued since reset or last pat_load
pat_done  output  1  pattern fully played; held high

Behaviour:
- Reset (rst=1 at posedge clk): state=IDLE, divider=0, step_en=0, fsm_in=0, step_cnt=0, pat_done=0, pattern register=0, length=0, bit index=0, synchroniser and debounced level=0, debounce counter=0. rst has priority over every other input.
- States: IDLE (mode 0), AUTO (mode 1), SINGLE (mode 2), PATTERN (mode 3), DONE (mode 3, finished).
- mode is sampled every cycle. If mode does not match the current state, the next state is the state for that mode (mode 3 enters PATTERN). On any state change: divider=0, bit index=0, pat_done=0. A mode change mid-pattern aborts playback.
- Divider:
  - Counts 0..CNT_MAX only in AUTO and PATTERN; held at 0 elsewhere.
  - Tick occurs in the cycle where divider==CNT_MAX; divider then wraps to 0.
- step_en and fsm_in are registered, so each is high in the cycle after the triggering event.
  - AUTO: step_en on each tick, fsm_in=in_manual sampled at the tick. The first pulse comes CNT_MAX+1 cycles after entering AUTO, then one every CNT_MAX+1 cycles.
  - SINGLE: step_en one cycle after a debounced rising edge, fsm_in=in_manual. Presses in any other state are ignored; no press is queued.
  - PATTERN, on each tick: step_en=1, fsm_in=pattern[index], index increments. When the incremented index equals the length, the next state is DONE and pat_done=1 together with that last step_en.
  - PATTERN with length 0: go to DONE and set pat_done on the next cycle, with no step.
  - DONE: no steps. Stays in DONE while mode==3.
  - IDLE: no steps.
- step_cnt increments by 1 on every cycle where step_en=1. It is 8-bit and wraps 255 to 0.
- pat_load is accepted in any state.
  - Captures pat_data and clamp(pat_len); clears index, divider, step_cnt and pat_done.
  - If in DONE with mode==3, returns to PATTERN.
  - If pat_load coincides with a tick, the load wins and no step is issued.
- Button path:
  - btn goes through a 2-flop synchroniser.
  - Debounce counter increments while the synchronised level differs from the debounced level and resets to 0 when they match.
  - At DB_CYCLES the debounced level takes the synchronised level and the counter clears.
  - A press is a 0 to 1 transition of the debounced level. Debouncing runs in all states.
- fsm_in holds its last value when step_en=0.

Test Plan (CNT_MAX=3, DB_CYCLES=4):
1. rst=1 for 2 cycles with mode=1 and btn=1 -> all outputs 0; after release in AUTO, first step_en 4 cycles later, then every 4 cycles; step_cnt=1,2,3.
2. mode=2, btn toggles 1/0/1 for 3 cycles, then held 1 -> exactly one step_en, about 7 cycles after btn settles; fsm_in=in_manual; holding btn gives no further pulses; a second clean press gives step_cnt=2.
3. pat_load with pat_data=8'b0000_1101, pat_len=4, mode=3 -> step_en every 4 cycles with fsm_in sequence 1,0,1,1; pat_done=1 on the 4th pulse; no further pulses; step_cnt=4.
4. During step 2 of scenario 3, set mode=0 -> no further steps, pat_done=0; return to mode=3 -> playback restarts at bit 0.
5. pat_load asserted in the same cycle as a tick in PATTERN -> no step_en on that tick; step_cnt=0; next step 4 cycles later plays bit 0.
6. pat_len=0 -> pat_done=1 within 2 cycles with no step_en; pat_len=12 with PAT_W=8 -> exactly 8 steps.
